// File: rtl/multi_channel_light_manager_pkg.sv
// Shared types and helpers for the encoder-driven multi-channel PWM light manager.
package light_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CW1  = 3'd1,
        CW2  = 3'd2,
        CW3  = 3'd3,
        CCW1 = 3'd4,
        CCW2 = 3'd5,
        CCW3 = 3'd6,
        WAIT = 3'd7
    } enc_state_t;

    function automatic int unsigned debounce_cycles(input int unsigned mhz, input int unsigned us);
        return mhz * us;
    endfunction

    // Saturating ops on a w-bit value (w <= 31); evaluated in 32 bits so nothing wraps.
    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [31:0] step,
                                            input int unsigned w);
        logic [31:0] maxv;
        maxv = (32'd1 << w) - 32'd1;
        return (v > maxv - step) ? maxv : v + step;
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] v, input logic [31:0] step,
                                            input int unsigned w);
        logic [31:0] maxv;
        maxv = (32'd1 << w) - 32'd1;
        return (v < step) ? 32'd0 : ((v - step) & maxv);
    endfunction

endpackage

// File: rtl/multi_channel_light_manager_debouncer.sv
// 2-FF synchroniser followed by a stability counter; idles high.
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
            r_q    <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], d_i};
            if (r_sync[1] != r_q) begin
                if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_q   <= r_sync[1];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign q_o = r_q;
endmodule

// File: rtl/multi_channel_light_manager.sv
// Rotary encoder + select button driving CHANNELS saturating-brightness PWM LED channels.
module multi_channel_light_manager
    import light_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ_MHZ = 100,
    parameter int unsigned DELAY_IN_US    = 1,
    parameter int unsigned PWM_VALUE_SIZE = 8,
    parameter int unsigned BRIGHTNESS_INC = 10,
    parameter int unsigned CHANNELS       = 4,
    localparam int unsigned CH_W          = $clog2(CHANNELS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      a_i,
    input  logic                      b_i,
    input  logic                      sel_i,
    output logic [CHANNELS-1:0]       leds_o,
    output logic [CH_W-1:0]           active_ch_o,
    output logic [PWM_VALUE_SIZE-1:0] brightness_o
);
    localparam int unsigned DEB = debounce_cycles(CLOCK_FREQ_MHZ, DELAY_IN_US);
    localparam logic [PWM_VALUE_SIZE-1:0] MAXV = '1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    logic w_a, w_b, w_sel;

    input_debouncer #(.DEBOUNCE_CYCLES(DEB)) u_deb_a   (.clk_i(clk_i), .rst_i(rst_i), .d_i(a_i),   .q_o(w_a));
    input_debouncer #(.DEBOUNCE_CYCLES(DEB)) u_deb_b   (.clk_i(clk_i), .rst_i(rst_i), .d_i(b_i),   .q_o(w_b));
    input_debouncer #(.DEBOUNCE_CYCLES(DEB)) u_deb_sel (.clk_i(clk_i), .rst_i(rst_i), .d_i(sel_i), .q_o(w_sel));

    enc_state_t r_state, w_state_nxt;
    logic       w_inc, w_dec;
    logic       r_inc, r_dec, r_sel_prev, r_sel_fall;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_inc      <= 1'b0;
            r_dec      <= 1'b0;
            r_sel_prev <= 1'b1;
            r_sel_fall <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inc      <= w_inc;
            r_dec      <= w_dec;
            r_sel_prev <= w_sel;
            r_sel_fall <= r_sel_prev & ~w_sel;
        end
    end

    // Full-detent decode: 11 -> 01 -> 00 -> 10 -> 11 is one clockwise click.
    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            IDLE: case ({w_a, w_b})
                2'b01: w_state_nxt = CW1;
                2'b10: w_state_nxt = CCW1;
                2'b00: w_state_nxt = WAIT;
                default: w_state_nxt = IDLE;
            endcase
            CW1: case ({w_a, w_b})
                2'b00: w_state_nxt = CW2;
                2'b11: w_state_nxt = IDLE;
                2'b10: w_state_nxt = WAIT;
                default: w_state_nxt = CW1;
            endcase
            CW2: case ({w_a, w_b})
                2'b10: w_state_nxt = CW3;
                2'b01: w_state_nxt = CW1;
                2'b11: w_state_nxt = IDLE;
                default: w_state_nxt = CW2;
            endcase
            CW3: case ({w_a, w_b})
                2'b11: begin w_state_nxt = IDLE; w_inc = 1'b1; end
                2'b00: w_state_nxt = CW2;
                2'b01: w_state_nxt = WAIT;
                default: w_state_nxt = CW3;
            endcase
            CCW1: case ({w_a, w_b})
                2'b00: w_state_nxt = CCW2;
                2'b11: w_state_nxt = IDLE;
                2'b01: w_state_nxt = WAIT;
                default: w_state_nxt = CCW1;
            endcase
            CCW2: case ({w_a, w_b})
                2'b01: w_state_nxt = CCW3;
                2'b10: w_state_nxt = CCW1;
                2'b11: w_state_nxt = IDLE;
                default: w_state_nxt = CCW2;
            endcase
            CCW3: case ({w_a, w_b})
                2'b11: begin w_state_nxt = IDLE; w_dec = 1'b1; end
                2'b00: w_state_nxt = CCW2;
                2'b10: w_state_nxt = WAIT;
                default: w_state_nxt = CCW3;
            endcase
            default: w_state_nxt = ({w_a, w_b} == 2'b11) ? IDLE : WAIT;
        endcase
    end

    logic [CHANNELS-1:0][PWM_VALUE_SIZE-1:0] r_bright;
    logic [CH_W-1:0]                         r_ch;

    // A step lands on the channel selected before any same-cycle select.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bright <= '0;
            r_ch     <= '0;
        end else begin
            if (r_inc)
                r_bright[r_ch] <= PWM_VALUE_SIZE'(sat_add(32'(r_bright[r_ch]), 32'(BRIGHTNESS_INC), PWM_VALUE_SIZE));
            else if (r_dec)
                r_bright[r_ch] <= PWM_VALUE_SIZE'(sat_sub(32'(r_bright[r_ch]), 32'(BRIGHTNESS_INC), PWM_VALUE_SIZE));
            if (r_sel_fall)
                r_ch <= (r_ch == LAST_CH) ? '0 : r_ch + 1'b1;
        end
    end

    logic [PWM_VALUE_SIZE-1:0] r_pwm_cnt;
    logic [CHANNELS-1:0]       w_leds, r_leds;
    logic [CH_W-1:0]           r_ch_o;
    logic [PWM_VALUE_SIZE-1:0] r_bright_o;

    always_comb begin
        w_leds = '0;
        for (int k = 0; k < CHANNELS; k++)
            w_leds[k] = (r_bright[k] == MAXV) || (r_pwm_cnt < r_bright[k]);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pwm_cnt  <= '0;
            r_leds     <= '0;
            r_ch_o     <= '0;
            r_bright_o <= '0;
        end else begin
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
            r_leds     <= w_leds;
            r_ch_o     <= r_ch;
            r_bright_o <= r_bright[r_ch];
        end
    end

    assign leds_o       = r_leds;
    assign active_ch_o  = r_ch_o;
    assign brightness_o = r_bright_o;
endmodule

// File: doc/multi_channel_light_manager.md
Name: multi_channel_light_manager

Overview:
- Successor to the single-set encoder/PWM light manager: one quadrature rotary encoder plus a select push-button drive CHANNELS independent PWM LED channels.
- Encoder A/B and the button are synchronised and debounced, and the encoder is decoded by a full-detent FSM.
- Each detent adjusts the brightness of the currently selected channel, with saturation. The button advances the selected channel, with wrap-around.
- Sits between board GPIO and the LED pins.

Parameters:
- CLOCK_FREQ_MHZ, 100, clock frequency in MHz; legal range 2..655.
- DELAY_IN_US, 1, debounce stability window in µs; DEBOUNCE_CYCLES = CLOCK_FREQ_MHZ*DELAY_IN_US.
- PWM_VALUE_SIZE, 8, brightness and PWM counter width; MAX = 2^PWM_VALUE_SIZE-1.
- BRIGHTNESS_INC, 10, brightness change per detent; legal range 1..MAX.
- CHANNELS, 4, number of LED channels; must be at least 2.
- CH_W, $clog2(CHANNELS), width of the channel index (derived, localparam).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset.
- a_i  in  1  encoder phase A, raw and asynchronous; idle high.
- b_i  in  1  encoder phase B, raw and asynchronous; idle high.
- sel_i  in  1  channel-select button, raw; idle high, pressed low.
- leds_o  out  CHANNELS  PWM outputs; bit k is channel k.
- active_ch_o  out  CH_W  index of the selected channel.
- brightness_o  out  PWM_VALUE_SIZE  brightness of the selected channel.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low (rst_i=0 resets).
- Reset values:
  - leds_o=0, active_ch_o=0, brightness_o=0, all brightness registers 0.
  - PWM counter 0, decoder FSM in IDLE.
  - Synchroniser and debounced outputs 1.
  - Debounce counters 0.
- Synchronisation: each raw input passes a 2-FF synchroniser.
- Debounce:
  - The debounced output takes a new value only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the old value clears the counter.
  - Latency from a clean raw edge to the debounced edge is 2+DEBOUNCE_CYCLES cycles.
- Decoder FSM, driven by debounced {A,B}:
  - States: IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3, WAIT.
  - From IDLE: 01 -> CW1 (A leads = right); 10 -> CCW1; 00 -> WAIT (illegal double change).
  - Clockwise path: CW1 -00-> CW2, CW2 -10-> CW3, CW3 -11-> IDLE and emits a one-cycle inc pulse.
  - Counter-clockwise path: CCW1 -00-> CCW2, CCW2 -01-> CCW3, CCW3 -11-> IDLE and emits a one-cycle dec pulse.
  - Reversal steps back one state: CW2 -01-> CW1, CW3 -00-> CW2, and the mirror moves on the CCW side.
  - 11 seen in any state other than CW3/CCW3 -> IDLE with no pulse.
  - Any other illegal code -> WAIT. WAIT exits to IDLE only on 11.
- Brightness update, on the cycle after a pulse, applied to the selected channel only:
  - inc: b = (b > MAX-INC) ? MAX : b+INC.
  - dec: b = (b < INC) ? 0 : b-INC.
  - Arithmetic uses PWM_VALUE_SIZE+1 bits, so there is no wrap.
- Channel select:
  - Trigger: falling edge of the debounced sel.
  - Action: active_ch = (active_ch==CHANNELS-1) ? 0 : active_ch+1.
  - If a select and a step occur in the same cycle, the step applies to the old channel and the select takes effect in that same update.
- PWM:
  - A free-running PWM_VALUE_SIZE counter wraps MAX -> 0, so the period is 2^PWM_VALUE_SIZE cycles.
  - leds_o[k] is registered: 1 if b[k]==MAX, otherwise (cnt < b[k]).
  - b=0 gives always off. b=MAX gives always on.
  - A brightness change is visible from the next counter compare; there is no period alignment.
- Status outputs: brightness_o = b[active_ch], registered, 1-cycle latency after a change.
- Reset mid-operation: all state returns to its reset value immediately; a rotation in progress produces no pulse.

Decomposition:
- Package light_pkg:
  - decoder state enum (enc_state_t);
  - DEBOUNCE_CYCLES computation function;
  - saturating add and subtract functions, parameterised on width.
- Sub-module input_debouncer:
  - parameter DEBOUNCE_CYCLES; ports clk_i, rst_i, d_i, q_o;
  - contains the 2-FF synchroniser and the stability counter;
  - instantiated three times (A, B, sel).
- The decoder FSM, brightness array and PWM stay in the top module.

Test Plan:
All scenarios use the default parameters (DEBOUNCE_CYCLES=100). "Bounce" means random toggling of the input for 100 cycles before it settles.
1. Reset: hold rst_i=0 for 1 µs with random inputs -> leds_o=0, active_ch_o=0, brightness_o=0 throughout; release -> all outputs stay 0.
2. One right detent (A falls with bounce, B falls 3 µs later, each low 5 µs, each rises with bounce) -> exactly one inc; brightness_o=10; leds_o[0] high for 10 of every 256 cycles; leds_o[3:1]=0.
3. 26 right detents -> brightness_o goes 250 then 255; leds_o[0] constantly 1. Then one left detent -> 245.
4. Left detent at brightness 0 -> brightness stays 0; leds_o[0] constantly 0.
5. Press sel four times -> active_ch_o goes 1,2,3,0 (wrap). After one press, a right detent -> b[1]=10 and b[0] unchanged.
6. Robustness, each case -> no brightness change:
   - a_i low pulse of 90 cycles;
   - A falls then rises before B moves (reversal);
   - A and B falling in the same cycle (WAIT);
   - rst_i pulsed low mid-detent.
